// File: rtl/toggle_event_receiver_if.sv
// Signal bundle between a toggle-event receiver and its consumer: the toggle
// line, the read-and-clear handshake and the status flags.
interface toggle_event_receiver_if #(
    parameter int COUNT_WIDTH = 8
);
    logic                   toggle_in;
    logic                   read_req;
    logic                   event_pulse;
    logic [COUNT_WIDTH-1:0] read_data;
    logic                   read_valid;
    logic                   overflow;
    logic                   pending;

    modport master (
        output toggle_in,
        output read_req,
        input  event_pulse,
        input  read_data,
        input  read_valid,
        input  overflow,
        input  pending
    );

    modport slave (
        input  toggle_in,
        input  read_req,
        output event_pulse,
        output read_data,
        output read_valid,
        output overflow,
        output pending
    );
endinterface

// File: rtl/toggle_event_receiver.sv
// Destination-domain end of a toggle-encoded event link: synchronises the toggle
// line, turns each level change into a pulse and counts events for a consumer.
module toggle_event_receiver #(
    parameter int SYNC_STAGES = 2,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                     clock,
    input  logic                     clear,
    toggle_event_receiver_if.slave   bus
);
    localparam logic [COUNT_WIDTH-1:0] CNT_ZERO = {COUNT_WIDTH{1'b0}};
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [COUNT_WIDTH-1:0] CNT_MAX  = {COUNT_WIDTH{1'b1}};

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   last_r;
    logic                   event_s;
    logic [COUNT_WIDTH-1:0] count_r;
    logic [COUNT_WIDTH-1:0] count_s;
    logic                   overflow_r;
    logic                   overflow_s;
    logic                   event_pulse_r;
    logic [COUNT_WIDTH-1:0] read_data_r;
    logic                   read_valid_r;
    logic                   pending_r;

    assign event_s = sync_r[SYNC_STAGES-1] ^ last_r;

    // Next count/overflow; a read clears the count but keeps a coincident event.
    always_comb begin
        count_s    = count_r;
        overflow_s = overflow_r;
        if (bus.read_req) begin
            count_s    = event_s ? CNT_ONE : CNT_ZERO;
            overflow_s = 1'b0;
        end else if (event_s) begin
            if (count_r == CNT_MAX) begin
                overflow_s = 1'b1;
            end else begin
                count_s = count_r + CNT_ONE;
            end
        end else begin
            count_s    = count_r;
            overflow_s = overflow_r;
        end
    end

    // All state advances on the falling edge; clear wipes everything at once.
    always_ff @(negedge clock or negedge clear) begin
        if (!clear) begin
            sync_r        <= {SYNC_STAGES{1'b0}};
            last_r        <= 1'b0;
            count_r       <= CNT_ZERO;
            overflow_r    <= 1'b0;
            event_pulse_r <= 1'b0;
            read_data_r   <= CNT_ZERO;
            read_valid_r  <= 1'b0;
            pending_r     <= 1'b0;
        end else begin
            sync_r        <= {sync_r[SYNC_STAGES-2:0], bus.toggle_in};
            last_r        <= sync_r[SYNC_STAGES-1];
            event_pulse_r <= event_s;
            count_r       <= count_s;
            overflow_r    <= overflow_s;
            pending_r     <= (count_s != CNT_ZERO);
            read_valid_r  <= bus.read_req;
            if (bus.read_req) begin
                read_data_r <= count_r;
            end else begin
                read_data_r <= read_data_r;
            end
        end
    end

    assign bus.event_pulse = event_pulse_r;
    assign bus.read_data   = read_data_r;
    assign bus.read_valid  = read_valid_r;
    assign bus.overflow    = overflow_r;
    assign bus.pending     = pending_r;
endmodule

// File: tb/tb_toggle_event_receiver.sv
// Randomised scoreboard bench for toggle_event_receiver: a history-based model
// queues expected pulses, reads and status; a monitor checks the DUT against them.
module tb_toggle_event_receiver;
    localparam int S  = 2;
    localparam int CW = 4;
    localparam logic [CW-1:0] SAT = 4'd15;

    typedef struct {
        int          cyc;
        logic [CW-1:0] data;
    } rd_t;

    typedef struct {
        logic pend;
        logic ovf;
    } st_t;

    logic clock = 1'b1;
    logic clear = 1'b0;

    toggle_event_receiver_if #(.COUNT_WIDTH(CW)) bus ();

    toggle_event_receiver #(.SYNC_STAGES(S), .COUNT_WIDTH(CW)) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic      hist[$];
    int        evt_q[$];
    rd_t       rd_q[$];
    st_t       st_q[$];
    logic [CW-1:0] m_count = 4'd0;
    logic      m_ovf = 1'b0;
    int        m_n;
    logic      m_a, m_b, m_ev;

    task automatic check_val(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference: an event appears S edges after the sampled toggle level changes.
    always @(negedge clock or negedge clear) begin
        if (!clear) begin
            hist.delete();
            evt_q.delete();
            rd_q.delete();
            st_q.delete();
            m_count = 4'd0;
            m_ovf   = 1'b0;
        end else begin
            cyc++;
            hist.push_back(bus.toggle_in);
            m_n  = hist.size() - 1;
            m_a  = (m_n >= S)     ? hist[m_n-S]   : 1'b0;
            m_b  = (m_n >= S + 1) ? hist[m_n-S-1] : 1'b0;
            m_ev = (m_a != m_b);
            if (m_ev) evt_q.push_back(cyc);
            if (bus.read_req) begin
                rd_q.push_back('{cyc: cyc, data: m_count});
                m_count = m_ev ? 4'd1 : 4'd0;
                m_ovf   = 1'b0;
            end else if (m_ev) begin
                if (m_count == SAT) m_ovf = 1'b1;
                else m_count = m_count + 4'd1;
            end
            st_q.push_back('{pend: (m_count != 4'd0), ovf: m_ovf});
        end
    end

    st_t st_m;
    rd_t rd_m;
    int  ev_m;

    // Monitor: pops expectations whenever the DUT presents a pulse, read or status.
    always @(posedge clock) begin
        if (clear) begin
            if (st_q.size() > 0) begin
                st_m = st_q.pop_front();
                check_val("pending", int'(bus.pending), int'(st_m.pend));
                check_val("overflow", int'(bus.overflow), int'(st_m.ovf));
            end
            if (bus.event_pulse) begin
                if (evt_q.size() == 0) begin
                    check_val("unexpected_pulse", 1, 0);
                end else begin
                    ev_m = evt_q.pop_front();
                    check_val("pulse_cycle", cyc, ev_m);
                end
            end else if (evt_q.size() > 0 && evt_q[0] <= cyc) begin
                ev_m = evt_q.pop_front();
                check_val("missing_pulse", 0, 1);
            end
            if (bus.read_valid) begin
                if (rd_q.size() == 0) begin
                    check_val("unexpected_read_valid", 1, 0);
                end else begin
                    rd_m = rd_q.pop_front();
                    check_val("read_cycle", cyc, rd_m.cyc);
                    check_val("read_data", int'(bus.read_data), int'(rd_m.data));
                end
            end else if (rd_q.size() > 0 && rd_q[0].cyc <= cyc) begin
                rd_m = rd_q.pop_front();
                check_val("missing_read_valid", 0, 1);
            end
        end
    end

    task automatic step(int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic flip();
        bus.toggle_in = ~bus.toggle_in;
    endtask

    task automatic do_read();
        bus.read_req = 1'b1;
        step(1);
        bus.read_req = 1'b0;
    endtask

    task automatic check_zero(string tag);
        check_val({tag, "_event_pulse"}, int'(bus.event_pulse), 0);
        check_val({tag, "_read_data"},   int'(bus.read_data),   0);
        check_val({tag, "_read_valid"},  int'(bus.read_valid),  0);
        check_val({tag, "_overflow"},    int'(bus.overflow),    0);
        check_val({tag, "_pending"},     int'(bus.pending),     0);
    endtask

    int hold;

    initial begin
        bus.toggle_in = 1'b0;
        bus.read_req  = 1'b0;
        hold          = 0;
        step(3);
        check_zero("reset");
        #1 clear = 1'b1;
        step(10);

        // single event
        flip();
        step(6);

        // five events three cycles apart, then read
        for (int i = 0; i < 5; i++) begin
            flip();
            step(3);
        end
        step(3);
        do_read();
        step(3);

        // saturation with 17 events
        for (int i = 0; i < 17; i++) begin
            flip();
            step(2);
        end
        step(4);
        do_read();
        step(3);

        // read coinciding with an event while count is 3
        for (int i = 0; i < 3; i++) begin
            flip();
            step(2);
        end
        step(4);
        flip();
        step(2);
        do_read();
        step(4);
        do_read();
        step(2);

        // back-to-back toggles
        for (int i = 0; i < 4; i++) begin
            flip();
            step(1);
        end
        step(4);
        do_read();
        step(2);

        // random traffic with held reads
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0) flip();
            if (hold > 0) hold--;
            else if ($urandom_range(0, 9) == 0) hold = $urandom_range(1, 4);
            bus.read_req = (hold > 0);
            step(1);
        end
        bus.read_req = 1'b0;
        step(5);
        do_read();
        step(2);

        // asynchronous clear with count 7 and one event in flight
        for (int i = 0; i < 7; i++) begin
            flip();
            step(2);
        end
        step(4);
        flip();
        #1 clear = 1'b0;
        #1;
        check_zero("async_clear");
        bus.toggle_in = 1'b0;
        step(3);
        check_zero("held_clear");
        #1 clear = 1'b1;
        step(3);
        for (int i = 0; i < 3; i++) begin
            flip();
            step(3);
        end
        step(3);
        do_read();
        step(5);

        check_val("events_drained", evt_q.size(), 0);
        check_val("reads_drained", rd_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/toggle_event_receiver.md
Name: toggle_event_receiver

Overview:
- Receiving end of a toggle-encoded event link. A remote t_flipflop-style sender flips one wire once per event; this block turns each level change back into one event.
- It synchronises the asynchronous toggle line, detects every level change and emits a one-cycle event pulse.
- Events are accumulated in a saturating counter, which a consumer reads and clears through a request/valid handshake.
- Sits in the destination clock domain of every toggle-based event crossing.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on toggle_in; legal range 2..4.
- COUNT_WIDTH, 8, width of the event counter and read_data.

Ports:
- clock  input  1  domain clock; all state updates on the falling edge.
- clear  input  1  asynchronous, active-low reset. 0 resets all state immediately; deassertion takes effect at the next falling edge.
- toggle_in  input  1  asynchronous toggle line from the sender; each level change is one event.
- read_req  input  1  sampled at the falling edge; 1 requests a count read-and-clear.
- event_pulse  output  1  high for exactly one clock per detected event.
- read_data  output  COUNT_WIDTH  count captured by the last read; holds its value until the next read.
- read_valid  output  1  high for exactly one clock after a sampled read_req.
- overflow  output  1  sticky: an event arrived while the counter was saturated.
- pending  output  1  count is non-zero.

Behaviour:
- Reset (clear=0): the following are all 0 while clear is low:
  - sync chain s[0..SYNC_STAGES-1] and the last-seen register;
  - count, read_data, read_valid, event_pulse, overflow and pending.
- Sender must also be cleared so toggle_in=0 at release. If toggle_in=1 at release, exactly one event is detected; this is documented, not an error.
- Synchroniser:
  - s[0] <= toggle_in; s[i] <= s[i-1].
  - last <= s[SYNC_STAGES-1].
  - No logic between toggle_in and s[0].
- Detection: event_pulse <= s[SYNC_STAGES-1] XOR last (registered).
- Latency: a toggle stable before falling edge k gives event_pulse=1 after edge k+SYNC_STAGES, for exactly one cycle.
- Event rate limit:
  - Back-to-back toggles one cycle apart each produce their own pulse.
  - Toggles spaced by at least 2 cycles are all guaranteed to be counted.
  - Glitches shorter than one cycle may be missed; the sender is responsible.
- Counter, updated on the same edge as event_pulse:
  - event, no read: count+1, saturating at 2^COUNT_WIDTH-1.
  - event at saturation: count holds and overflow <= 1.
- Read handshake (read_req=1 at an edge):
  - read_data <= current count; read_valid=1 for that following cycle only.
  - count <= 0, or 1 if an event is detected on the same edge, so no event is lost.
  - overflow <= 0, or 1 if the simultaneous event hits saturation. Because count is cleared on that same edge, this case cannot occur.
- read_req held high: a read happens every cycle and read_valid stays high. Each read returns the events since the previous read.
- read_req with count=0: read_data=0, read_valid=1.
- pending <= (next count != 0), registered alongside count.
- Reset mid-read or mid-event: all state clears immediately; events in flight are discarded.

Test Plan:
- Reset: clear=0 with toggle_in=0 -> all outputs 0. Release, then idle 10 cycles -> no event_pulse, pending=0.
- Single event, SYNC_STAGES=2: toggle_in 0->1 before edge k -> event_pulse=1 after edge k+2 only. Count=1, pending=1.
- Five toggles spaced 3 cycles, then read_req -> five pulses; read_data=5 and read_valid for one cycle; count=0, pending=0.
- Saturation, COUNT_WIDTH=4: 17 events -> count=15, overflow=1. Read -> read_data=15, overflow=0, count=0.
- Simultaneous read and event with count=3 -> read_data=3, count=1 afterwards, pending=1.
- Async reset mid-stream: clear low between edges with count=7 -> count, pending and outputs 0 immediately. After release, new events count from 0.
